btn_write_ctrl: RTL
===================

Name: btn_write_ctrl

Overview:
Front-end input stage that feeds the 8-digit seven-segment display store with its write, num and sel inputs. Synchronises the board's raw push-button and slide switches, and debounces the button. Produces exactly one single-cycle write strobe per clean press, with num/sel captured and held stable alongside it. Sits between board I/O pins and the display memory, all in the clk domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a press or release (10 ms at 100 MHz); legal range >= 2
SYNC_STAGES, 2, flip-flop depth of the input synchronisers; legal range >= 2

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
btn_in  input  1  raw asynchronous push-button, high = pressed
sw_num  input  4  raw asynchronous hex digit switches
sw_sel  input  3  raw asynchronous digit-select switches
write  output  1  one-cycle write strobe to display store
num  output  4  digit value presented with write
sel  output  3  digit index presented with write
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state is sampled on posedge clk.
- Reset values:
  - write=0, num=0, sel=0, busy=0.
  - FSM state = IDLE, debounce counter = 0, all synchroniser flops = 0.
- Synchronisers:
  - btn_in, sw_num and sw_sel each pass through a SYNC_STAGES flop chain, giving btn_s, num_s and sel_s.
  - Switch values are not debounced; they are sampled only at the capture point defined below.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES). Cleared on every state transition. Never wraps, because the FSM leaves the state at terminal count DEBOUNCE_CYCLES-1.
- FSM states and transitions:
  - IDLE: btn_s=1 -> PRESS_DB.
  - PRESS_DB:
    - btn_s=0 -> IDLE (glitch rejected, no strobe).
    - btn_s=1 and count==DEBOUNCE_CYCLES-1 -> FIRE; on this transition register num<=num_s and sel<=sel_s.
    - Otherwise count+1.
  - FIRE: write=1 for exactly this one cycle; unconditional -> HELD.
  - HELD: btn_s=0 -> RELEASE_DB.
  - RELEASE_DB:
    - btn_s=1 -> HELD (bounce on release, no new strobe).
    - btn_s=0 and count==DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise count+1.
- write is a registered output, high only in FIRE. It is never high two consecutive cycles.
- Latency: write asserts DEBOUNCE_CYCLES+1 cycles after btn_s first rises, provided btn_s stays high throughout.
- Holding the button indefinitely yields one strobe. A new strobe requires a debounced release followed by a debounced press.
- num/sel hold their last captured values between strobes. Switch changes while not in the capture transition have no effect on the outputs.
- busy = (state != IDLE), registered alongside the state.
- Reset asserted mid-debounce or in FIRE: the next cycle has write=0 and state IDLE; no pending strobe survives reset.

Optional Feature:
AUTO_INC_EN
- Defined:
  - sel is driven from an internal 3-bit pointer (reset 0), and sw_sel is ignored.
  - The pointer post-increments in the FIRE cycle, wrapping 7->0, so consecutive presses fill digits 0,1,2,...
  - The sel presented with a strobe is the pre-increment value.
- Undefined: sel is captured from sel_s as described in Behaviour; no pointer logic is present.

Decomposition:
- Package btn_write_pkg:
  - NUM_DIGITS=8, DIGIT_W=4, SEL_W=3.
  - typedef enum logic [2:0] state_t {IDLE, PRESS_DB, FIRE, HELD, RELEASE_DB}.
- Sub-module sync_chain: parameterised WIDTH and STAGES, synchronous reset to 0. Instantiated for btn, num and sel.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_in high for 20 cycles with sw_num=4'hA, sw_sel=3 -> exactly one write pulse with num=A and sel=3. The pulse arrives 5 cycles after btn_s rises; busy stays high until after release is debounced.
- Bounce on press: btn_in toggles high 2 cycles, low 1 cycle, high 10 cycles -> exactly one write. Timing is measured from the final btn_s rise; the first burst produces no strobe.
- Bounce on release, then hold: after a strobe, btn_in goes low 2 cycles then high 10 cycles -> no second write, and the state returns to HELD.
- Switch change after capture: change sw_num from 5 to 9 during HELD -> num stays 5 until the next strobe.
- Reset mid-debounce: assert reset during PRESS_DB at count 2 -> write never asserts, and all outputs read 0 the following cycle.
- AUTO_INC_EN: nine clean presses -> sel sequence 0,1,...,7,0 on the strobes, while sw_sel is held at 5 throughout.

Source files
------------

// File: rtl/btn_write_pkg.sv
// rtl/btn_write_pkg.sv - shared constants and FSM state type for the button write front end
package btn_write_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    FIRE,
    HELD,
    RELEASE_DB
  } state_t;
endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-stage flop synchroniser with synchronous reset to zero
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];
endmodule

// File: rtl/btn_write_ctrl.sv
// rtl/btn_write_ctrl.sv - debounced push-button to single write strobe with captured num/sel
// AUTO_INC_EN: sel comes from an internal post-incrementing digit pointer instead of sw_sel.
module btn_write_ctrl
  import btn_write_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  input  logic [DIGIT_W-1:0] sw_num,
  input  logic [SEL_W-1:0]   sw_sel,
  output logic               write,
  output logic [DIGIT_W-1:0] num,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               btn_s;
  logic [DIGIT_W-1:0] num_s;
  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               write_next, busy_next, capture;

  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_btn (
    .clk(clk), .reset(reset), .d(btn_in), .q(btn_s)
  );
  sync_chain #(.WIDTH(DIGIT_W), .STAGES(SYNC_STAGES)) u_sync_num (
    .clk(clk), .reset(reset), .d(sw_num), .q(num_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      write <= 1'b0;
      busy  <= 1'b0;
      num   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      write <= write_next;
      busy  <= busy_next;
      if (capture) num <= num_s;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (btn_s) next_state = PRESS_DB;
      PRESS_DB:   if (!btn_s) next_state = IDLE;
                  else if (cnt == CNT_MAX) next_state = FIRE;
      FIRE:       next_state = HELD;
      HELD:       if (!btn_s) next_state = RELEASE_DB;
      RELEASE_DB: if (btn_s) next_state = HELD;
                  else if (cnt == CNT_MAX) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Counter only runs while waiting out a debounce window; any transition restarts it.
  always_comb begin
    cnt_next = '0;
    if (next_state == state && (state == PRESS_DB || state == RELEASE_DB))
      cnt_next = cnt + 1'b1;
    write_next = (next_state == FIRE);
    busy_next  = (next_state != IDLE);
    capture    = (state == PRESS_DB) && (next_state == FIRE);
  end

`ifdef AUTO_INC_EN
  logic [SEL_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      sel <= '0;
    end else begin
      if (capture) sel <= ptr;
      if (state == FIRE) ptr <= ptr + 1'b1;
    end
  end
`else
  logic [SEL_W-1:0] sel_s;

  sync_chain #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .reset(reset), .d(sw_sel), .q(sel_s)
  );

  always_ff @(posedge clk) begin
    if (reset) sel <= '0;
    else if (capture) sel <= sel_s;
  end
`endif
endmodule
